// File: rtl/hc_pkg.sv
// Shared definitions for the N3-to-N6 GTP-U decapsulation path.
package hc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR_PARSE,
    PAYLOAD_FWD,
    DROP
  } HC_N6_STATES;

  localparam logic [15:0] GTPU_UDP_PORT  = 16'd2152;
  localparam logic [7:0]  GTP_TPDU_TYPE  = 8'hFF;
  localparam logic [7:0]  IPV4_PROTO_UDP = 8'd17;
  localparam logic [3:0]  IPV4_VERSION   = 4'd4;
  localparam logic [2:0]  GTP_VERSION    = 3'd1;

endpackage

// File: rtl/hc_out_slice.sv
// Single registered valid/ready slice carrying a data word with sop/eop framing.
module hc_out_slice #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] data_i,
  input  logic         sop_i,
  input  logic         eop_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [W-1:0] data_o,
  output logic         sop_o,
  output logic         eop_o,
  output logic         valid_o,
  input  logic         ready_i
);

  logic [W-1:0] data_q;
  logic         sop_q;
  logic         eop_q;
  logic         valid_q;

  assign ready_o = !valid_q || ready_i;
  assign data_o  = data_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign valid_o = valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (valid_i && ready_o) begin
      data_q  <= data_i;
      sop_q   <= sop_i;
      eop_q   <= eop_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hc_n3_to_n6_decap.sv
// Strips IPv4/UDP/GTP-U encapsulation from N3 packets and forwards the inner payload to N6.
module hc_n3_to_n6_decap
  import hc_pkg::*;
#(
  parameter int unsigned ID_W       = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TEID_CHECK = 0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [31:0]      packet_i,
  input  logic             packet_valid_i,
  input  logic             packet_sop_i,
  input  logic             packet_eop_i,
  output logic             packet_ready_o,
  input  logic [31:0]      cfg_teid_i,
  output logic [31:0]      packet_o,
  output logic             packet_valid_o,
  output logic             packet_sop_o,
  output logic             packet_eop_o,
  input  logic             packet_ready_i,
  output logic [ID_W-1:0]  packet_id_o,
  output logic             drop_o,
  output logic             err_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  HC_N6_STATES      state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [3:0]       ihl_q, ihl_d;
  logic             ext_q, ext_d;
  logic             first_q, first_d;
  logic             drop_q, drop_d;
  logic             err_q, err_d;
  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] cnt_q;

  logic       rdy, accept, in_hdr, fail, fwd_valid, ext_eff;
  logic [3:0] ihl_eff;
  logic [4:0] ihl_w, cur_idx, hlen;

  // A sop word always restarts header parsing at index 0, whatever the current state.
  assign accept  = packet_valid_i && rdy;
  assign ihl_eff = packet_sop_i ? packet_i[27:24] : ihl_q;
  assign ext_eff = packet_sop_i ? 1'b0 : ext_q;
  assign cur_idx = packet_sop_i ? '0 : idx_q;
  assign ihl_w   = {1'b0, ihl_eff};
  assign hlen    = ihl_w + 5'd4 + {4'b0000, ext_eff};

  always_comb begin
    fail = 1'b0;
    if (cur_idx == 5'd0 && (packet_i[31:28] != IPV4_VERSION || packet_i[27:24] < 4'd5))
      fail = 1'b1;
    if (cur_idx == 5'd2 && packet_i[23:16] != IPV4_PROTO_UDP)
      fail = 1'b1;
    if (cur_idx == ihl_w && packet_i[15:0] != GTPU_UDP_PORT)
      fail = 1'b1;
    if (cur_idx == ihl_w + 5'd2 &&
        (packet_i[31:29] != GTP_VERSION || packet_i[23:16] != GTP_TPDU_TYPE))
      fail = 1'b1;
    if (TEID_CHECK != 0 && cur_idx == ihl_w + 5'd3 && packet_i != cfg_teid_i)
      fail = 1'b1;
    if (ext_eff && cur_idx == ihl_w + 5'd4 && packet_i[7:0] != 8'h00)
      fail = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ihl_d     = ihl_q;
    ext_d     = ext_q;
    first_d   = first_q;
    drop_d    = 1'b0;
    err_d     = 1'b0;
    fwd_valid = 1'b0;
    in_hdr    = packet_sop_i || (state_q == HDR_PARSE);
    if (accept) begin
      if (packet_sop_i && state_q != IDLE) err_d = 1'b1;
      if (in_hdr) begin
        ihl_d = ihl_eff;
        ext_d = ext_eff;
        idx_d = cur_idx + 5'd1;
        if (cur_idx == ihl_w + 5'd2) ext_d = |packet_i[26:24];
        // eop anywhere inside the header is a runt and counts as a drop.
        if (fail || packet_eop_i) begin
          drop_d  = 1'b1;
          state_d = packet_eop_i ? IDLE : DROP;
        end else if (cur_idx == hlen - 5'd1) begin
          state_d = PAYLOAD_FWD;
          first_d = 1'b1;
        end else begin
          state_d = HDR_PARSE;
        end
      end else begin
        case (state_q)
          PAYLOAD_FWD: begin
            fwd_valid = 1'b1;
            first_d   = 1'b0;
            if (packet_eop_i) state_d = IDLE;
          end
          DROP: begin
            if (packet_eop_i) state_d = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ihl_q   <= '0;
      ext_q   <= 1'b0;
      first_q <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ihl_q   <= ihl_d;
      ext_q   <= ext_d;
      first_q <= first_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      // The id advances only when a forwarded packet's last word actually leaves.
      if (packet_valid_o && packet_ready_i && packet_eop_o) id_q <= id_q + ID_W'(1);
      if (drop_d && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  hc_out_slice #(.W(32)) u_out_slice (
    .clk_i   (CLK),
    .rst_i   (reset),
    .data_i  (packet_i),
    .sop_i   (first_q),
    .eop_i   (packet_eop_i),
    .valid_i (fwd_valid),
    .ready_o (rdy),
    .data_o  (packet_o),
    .sop_o   (packet_sop_o),
    .eop_o   (packet_eop_o),
    .valid_o (packet_valid_o),
    .ready_i (packet_ready_i)
  );

  assign packet_ready_o = rdy;
  assign packet_id_o    = id_q;
  assign drop_o         = drop_q;
  assign err_o          = err_q;
  assign drop_cnt_o     = cnt_q;

endmodule

// File: tb/tb_hc_n3_to_n6_decap.sv
// Scoreboard bench for hc_n3_to_n6_decap: packet-level reference model, randomized traffic.
module tb_hc_n3_to_n6_decap;

  localparam int ID_W  = 4;
  localparam int CNT_W = 3;

  logic              CLK = 1'b0;
  logic              reset;
  logic [31:0]       packet_i;
  logic              packet_valid_i, packet_sop_i, packet_eop_i, packet_ready_o;
  logic [31:0]       cfg_teid_i;
  logic [31:0]       packet_o;
  logic              packet_valid_o, packet_sop_o, packet_eop_o, packet_ready_i;
  logic [ID_W-1:0]   packet_id_o;
  logic              drop_o, err_o;
  logic [CNT_W-1:0]  drop_cnt_o;

  hc_n3_to_n6_decap #(.ID_W(ID_W), .CNT_W(CNT_W), .TEID_CHECK(1)) dut (
    .CLK(CLK), .reset(reset),
    .packet_i(packet_i), .packet_valid_i(packet_valid_i), .packet_sop_i(packet_sop_i),
    .packet_eop_i(packet_eop_i), .packet_ready_o(packet_ready_o), .cfg_teid_i(cfg_teid_i),
    .packet_o(packet_o), .packet_valid_o(packet_valid_o), .packet_sop_o(packet_sop_o),
    .packet_eop_o(packet_eop_o), .packet_ready_i(packet_ready_i), .packet_id_o(packet_id_o),
    .drop_o(drop_o), .err_o(err_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]     d;
    logic            sop;
    logic            eop;
    logic [ID_W-1:0] id;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pw[$];
  int checks = 0, failures = 0;
  int exp_drops = 0, exp_errs = 0, seen_drops = 0, seen_errs = 0;
  logic [ID_W-1:0] model_id = '0;
  int cyc = 0, rdy_mode = 0, lat_start = -1, lat_seen = -1;
  bit mon_en = 0, prev_stall = 0;
  logic [31:0] prev_d;

  always @(posedge CLK) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  initial begin
    packet_ready_i = 1'b1;
    forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
        1:       packet_ready_i = ~packet_ready_i;
        2:       packet_ready_i = ($urandom_range(0, 3) != 0);
        default: packet_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output transfer.
  always @(negedge CLK) begin
    exp_t e, got;
    if (mon_en) begin
      if (drop_o) seen_drops++;
      if (err_o) seen_errs++;
      if (prev_stall) check("hold", {31'b0, packet_valid_o, packet_o}, {31'b0, 1'b1, prev_d});
      if (packet_valid_o && lat_start >= 0 && lat_seen < 0) lat_seen = cyc;
      if (packet_valid_o && packet_ready_i) begin
        got = {packet_o, packet_sop_o, packet_eop_o, packet_id_o};
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(got), 64'd0);
        end else begin
          e = sb.pop_front();
          check("out_word", 64'(got), 64'(e));
        end
      end
    end
    prev_stall = mon_en && packet_valid_o && !packet_ready_i;
    prev_d     = packet_o;
  end

  task automatic build(input int ihl, input logic [2:0] efl, input int plen,
                       input logic [31:0] teid, input int bad);
    logic [31:0] r, t;
    pw.delete();
    pw.push_back({4'h4, 4'(ihl), 8'h00, 16'((ihl + 4 + plen) * 4)});
    for (int i = 1; i < ihl; i++) pw.push_back($urandom);
    r = $urandom; pw[2] = {8'd64, 8'd17, r[15:0]};
    r = $urandom; pw.push_back({r[31:16], 16'd2152});
    pw.push_back($urandom);
    pw.push_back({5'b00110, efl, 8'hFF, 16'(plen * 4)});
    pw.push_back(teid);
    if (efl != 3'b000) begin r = $urandom; pw.push_back({r[31:8], 8'h00}); end
    for (int i = 0; i < plen; i++) pw.push_back($urandom);
    case (bad)
      1: begin t = pw[0];     t[31:28] = 4'h6;     pw[0] = t;     end
      2: begin t = pw[0];     t[27:24] = 4'h4;     pw[0] = t;     end
      3: begin t = pw[2];     t[23:16] = 8'd6;     pw[2] = t;     end
      4: begin t = pw[ihl];   t[15:0]  = 16'd2153; pw[ihl] = t;   end
      5: begin t = pw[ihl+2]; t[31:29] = 3'd2;     pw[ihl+2] = t; end
      6: begin t = pw[ihl+2]; t[23:16] = 8'h01;    pw[ihl+2] = t; end
      7: pw[ihl+3] = teid ^ 32'h1;
      8: if (efl != 3'b000) begin t = pw[ihl+4]; t[7:0] = 8'h05; pw[ihl+4] = t; end
      default: ;
    endcase
  endtask

  // Index of the first header word violating the encapsulation rules, -1 if none among n words.
  function automatic int first_fail(input int n, input logic [31:0] cfg);
    logic [31:0] w0, w;
    int ihl;
    w0 = pw[0];
    ihl = int'(w0[27:24]);
    if (w0[31:28] != 4'h4 || ihl < 5) return 0;
    if (n > 2) begin w = pw[2]; if (w[23:16] != 8'd17) return 2; end
    if (n > ihl) begin w = pw[ihl]; if (w[15:0] != 16'd2152) return ihl; end
    if (n > ihl + 2) begin
      w = pw[ihl+2];
      if (w[31:29] != 3'd1 || w[23:16] != 8'hFF) return ihl + 2;
    end
    if (n > ihl + 3) begin w = pw[ihl+3]; if (w != cfg) return ihl + 3; end
    if (n > ihl + 4) begin
      w = pw[ihl+2];
      if (w[26:24] != 3'b000) begin w = pw[ihl+4]; if (w[7:0] != 8'h00) return ihl + 4; end
    end
    return -1;
  endfunction

  task automatic model_pkt(input int n, input bit has_eop);
    int ff, ihl, hlen;
    logic [31:0] w;
    exp_t e;
    ff = first_fail(n, cfg_teid_i);
    if (ff >= 0) begin
      exp_drops++;
    end else begin
      w = pw[0]; ihl = int'(w[27:24]);
      w = pw[ihl+2];
      hlen = ihl + 4 + ((w[26:24] != 3'b000) ? 1 : 0);
      if (n <= hlen) begin
        if (has_eop) exp_drops++;
      end else begin
        for (int i = hlen; i < n; i++) begin
          e.d = pw[i]; e.sop = (i == hlen); e.eop = has_eop && (i == n - 1); e.id = model_id;
          sb.push_back(e);
        end
        if (has_eop) model_id++;
      end
    end
    if (!has_eop) exp_errs++;
  endtask

  task automatic send_word(input logic [31:0] w, input logic s, input logic e);
    int t = 0;
    bit done = 0;
    packet_i = w; packet_sop_i = s; packet_eop_i = e; packet_valid_i = 1'b1;
    while (!done) begin
      @(negedge CLK); done = packet_ready_o;
      @(posedge CLK); #1;
      t++;
      if (!done && t > 200) begin
        failures++;
        $display("FAIL send_timeout actual=ready_low required=ready_high");
        $fatal(1, "input never accepted");
      end
    end
    packet_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit has_eop, input bit gaps);
    model_pkt(n, has_eop);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
      send_word(pw[i], i == 0, has_eop && i == n - 1);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || packet_valid_o) && t < 1000) begin @(posedge CLK); #1; t++; end
    repeat (3) begin @(posedge CLK); #1; end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int d0, e0, n, exp_cnt;
    bit abort;
    reset = 1'b1; packet_valid_i = 1'b0; packet_i = '0; packet_sop_i = 1'b0;
    packet_eop_i = 1'b0; cfg_teid_i = 32'hCAFE_0001;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_outputs", 64'({packet_valid_o, packet_sop_o, packet_eop_o, drop_o, err_o,
                              packet_o, packet_id_o, drop_cnt_o}), 64'd0);
    @(posedge CLK); #1;
    reset = 1'b0;
    check("rst_ready", 64'(packet_ready_o), 64'd1);
    mon_en = 1;

    // Plain packet: IHL 5, flags 0x30, three payload words; latency and id step.
    build(5, 3'b000, 3, cfg_teid_i, 0);
    lat_start = cyc;
    send_pkt(pw.size(), 1, 0);
    drain();
    check("first_out_latency", 64'(lat_seen - lat_start), 64'd10);
    check("id_after_first", 64'(packet_id_o), 64'd1);

    // Sequence-number flag: ten header words stripped.
    build(5, 3'b010, 2, cfg_teid_i, 0);
    send_pkt(pw.size(), 1, 0);
    drain();

    // TEID mismatch is dropped, next matching packet forwarded.
    cfg_teid_i = 32'h1234;
    d0 = seen_drops;
    build(5, 3'b000, 3, 32'h5678, 0);
    send_pkt(pw.size(), 1, 0);
    drain();
    check("teid_drop_pulses", 64'(seen_drops - d0), 64'd1);
    check("teid_drop_cnt", 64'(drop_cnt_o), 64'd1);
    build(5, 3'b000, 3, cfg_teid_i, 0);
    send_pkt(pw.size(), 1, 0);
    drain();

    // Alternating output ready over an eight-word payload.
    rdy_mode = 1;
    build(6, 3'b000, 8, cfg_teid_i, 0);
    send_pkt(pw.size(), 1, 0);
    drain();
    rdy_mode = 0;

    // sop in the middle of a payload.
    e0 = seen_errs;
    build(5, 3'b000, 6, cfg_teid_i, 0);
    send_pkt(11, 0, 0);
    build(7, 3'b100, 3, cfg_teid_i, 0);
    send_pkt(pw.size(), 1, 0);
    drain();
    check("err_pulse", 64'(seen_errs - e0), 64'd1);

    for (int k = 0; k < 70; k++) begin
      rdy_mode = $urandom_range(0, 2);
      build($urandom_range(5, 7),
            ($urandom_range(0, 2) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000,
            $urandom_range(0, 6), cfg_teid_i,
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0);
      abort = (k < 69) && ($urandom_range(0, 9) == 0);
      n = abort ? $urandom_range(1, pw.size() - 1) : pw.size();
      send_pkt(n, !abort, 1);
      if (!abort && $urandom_range(0, 7) == 0) send_word($urandom, 1'b0, 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    drain();
    exp_cnt = (exp_drops > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : exp_drops;
    check("total_drop_pulses", 64'(seen_drops), 64'(exp_drops));
    check("total_err_pulses", 64'(seen_errs), 64'(exp_errs));
    check("drop_cnt_sat", 64'(drop_cnt_o), 64'(exp_cnt));
    check("packet_id_final", 64'(packet_id_o), 64'(model_id));

    // Reset while payload is in flight, then orphan words must be ignored.
    mon_en = 0;
    build(5, 3'b000, 8, cfg_teid_i, 0);
    for (int i = 0; i < 11; i++) send_word(pw[i], i == 0, 1'b0);
    check("rstmid_pre_valid", 64'(packet_valid_o), 64'd1);
    reset = 1'b1;
    #1;
    check("rstmid_valid", 64'(packet_valid_o), 64'd0);
    check("rstmid_id_cnt", 64'({packet_id_o, drop_cnt_o}), 64'd0);
    @(posedge CLK); #1;
    reset = 1'b0;
    sb.delete();
    model_id = '0;
    mon_en = 1;
    send_word(pw[11], 1'b0, 1'b0);
    send_word(pw[12], 1'b0, 1'b1);
    build(5, 3'b001, 2, cfg_teid_i, 0);
    send_pkt(pw.size(), 1, 0);
    drain();
    check("post_rst_id", 64'(packet_id_o), 64'd1);
    check("post_rst_drop_cnt", 64'(drop_cnt_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hc_n3_to_n6_decap.md
HC_N3_TO_N6_DECAP -- requirements
Module: hc_n3_to_n6_decap

Interface
REQ-001 SHALL have parameter ID_W, default 16: width of packet_id_o.
REQ-002 SHALL have parameter CNT_W, default 16: width of drop_cnt_o.
REQ-003 SHALL have parameter TEID_CHECK, default 0: when 1, packets whose TEID differs from cfg_teid_i are dropped.
REQ-004 SHALL have port CLK  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-005 SHALL have input-side ports: packet_i in 32 (N3 word, network byte order, bit 31 first); packet_valid_i in 1; packet_sop_i in 1; packet_eop_i in 1; packet_ready_o out 1.
REQ-006 SHALL have input cfg_teid_i  in  32  expected TEID, sampled on the TEID word.
REQ-007 SHALL have output-side ports: packet_o out 32 (N6 word); packet_valid_o out 1; packet_sop_o out 1; packet_eop_o out 1; packet_ready_i in 1.
REQ-008 SHALL have status outputs: packet_id_o out ID_W (id of current output packet); drop_o out 1 (one-cycle pulse per dropped packet); err_o out 1 (one-cycle pulse per truncated packet); drop_cnt_o out CNT_W.

Function
REQ-009 Input word transfers when packet_valid_i && packet_ready_o; output word transfers when packet_valid_o && packet_ready_i.
REQ-010 packet_ready_o SHALL equal !packet_valid_o || packet_ready_i (single registered output slice, 1-cycle latency, no bubbles under continuous ready).
REQ-011 States: IDLE, HDR_PARSE, PAYLOAD_FWD, DROP.
REQ-012 IDLE: accepted word with sop -> HDR_PARSE, header word index = 0; words without sop are discarded silently.
REQ-013 HDR_PARSE checks, word-indexed: w0 version==4 and IHL>=5; w2 protocol==17; w(IHL) UDP dport==2152; w(IHL+2) GTP version==1 and msg type==0xFF; w(IHL+3) TEID==cfg_teid_i if TEID_CHECK.
REQ-014 Header length H = IHL+4 words, plus 1 when any GTP flag E/S/PN (flags bits 2:0 of w(IHL+2)) is set; on that extra word, next-extension-type != 0 fails the checks.
REQ-015 Any failed check -> DROP; if the failing word carries eop, go directly to IDLE. drop_o pulses exactly once per dropped packet.
REQ-016 eop at or before header word H-1 (runt or zero payload) SHALL count as drop; no output word is produced.
REQ-017 After word H-1 passes -> PAYLOAD_FWD; first payload word emitted with packet_sop_o=1, input eop copied to packet_eop_o; eop -> IDLE.
REQ-018 DROP consumes words with packet_ready_o=1 until eop, then -> IDLE.
REQ-019 sop received in HDR_PARSE, PAYLOAD_FWD or DROP SHALL pulse err_o, abandon the current packet without emitting eop, and restart HDR_PARSE on that word.
REQ-020 packet_id_o SHALL increment by 1 after each forwarded eop, wrapping 2^ID_W-1 -> 0; dropped packets do not consume an id.
REQ-021 drop_cnt_o increments per drop_o pulse, saturating at 2^CNT_W-1.
REQ-022 Input back-pressure SHALL never lose or duplicate a word; packet_o stable while packet_valid_o && !packet_ready_i.

Reset
REQ-023 On reset assertion, immediately: state IDLE; packet_valid_o, packet_sop_o, packet_eop_o, drop_o, err_o = 0; packet_o = 0; packet_id_o = 0; drop_cnt_o = 0; packet_ready_o = 1 after release.
REQ-024 Reset mid-packet SHALL discard the partial packet; the next word is processed only if it carries sop.

Structure
REQ-025 Shared package hc_pkg SHALL hold state enum HC_N6_STATES, GTPU_UDP_PORT=2152, GTP_TPDU_TYPE=8'hFF, IPV4_PROTO_UDP=8'd17.
REQ-026 Output register slice SHALL be a sub-module hc_out_slice (data, sop, eop, valid/ready).

Verification
REQ-027 Valid packet: IHL=5, dport 2152, flags 0x30, 3 payload words A,B,C -> output A(sop),B,C(eop) 10 cycles after first input word; packet_id_o 0 -> 1.
REQ-028 Flags 0x32 (S set), ext type 0, 2 payload words -> header 10 words stripped, 2 words out.
REQ-029 TEID_CHECK=1, cfg_teid_i=0x1234, packet TEID 0x5678 -> no output, drop_o one pulse, drop_cnt_o=1, next valid packet forwarded.
REQ-030 packet_ready_i toggling 1010... during 8-word payload -> all 8 words out in order, none lost or duplicated.
REQ-031 sop mid-payload -> err_o pulse, new packet parsed correctly; reset asserted mid-payload -> packet_valid_o=0 at once, packet_id_o=0.
